fifo_wr_arbiter: RTL and testbench

- Round-robin arbiter that shares the single write port of a fifo instance between N requesters.
- Optional locked bursts let one requester write several consecutive words.
- Sits between producer blocks (ALU result paths, input loaders) and the FIFO.
- Drives the FIFO's write data and write-enable, and honours its full flag as backpressure.

---
 rtl/fifo_wr_arbiter.sv | 127 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N requesters, with optional locked bursts.
// Latency: one clock from the transfer edge to the registered write; ack is held low while fifo_full=1.
module fifo_wr_arbiter #(
    parameter int W         = 8,
    parameter int N         = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         lock,
    input  logic [N*W-1:0]       data,
    output logic [N-1:0]         ack,
    input  logic                 fifo_full,
    output logic [W-1:0]         fifo_din,
    output logic                 fifo_wr,
    output logic                 busy,
    output logic [$clog2(N)-1:0] owner
);

    localparam int OW = $clog2(N);
    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t        state_q;
    logic [OW-1:0] rr_ptr_q;
    logic [OW-1:0] rr_ptr_d;
    logic [OW-1:0] owner_q;
    logic [7:0]    burst_cnt_q;
    logic          fifo_wr_q;
    logic [W-1:0]  fifo_din_q;

    logic          grant_found;
    logic [OW-1:0] grant_idx;
    logic [OW:0]   cand;
    logic [OW-1:0] xfer_idx;
    logic          xfer;
    logic [W-1:0]  xfer_dat;

    // First requester at or after rr_ptr, wrapping modulo N.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, rr_ptr_q} + (OW+1)'(k);
            if (cand >= (OW+1)'(N)) begin
                cand = cand - (OW+1)'(N);
            end
            if (!grant_found && req[cand[OW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[OW-1:0];
            end
        end
    end

    always_comb begin
        ack      = '0;
        xfer_idx = (state_q == BURST) ? owner_q : grant_idx;
        if (rst && !fifo_full) begin
            if (state_q == BURST) begin
                ack[owner_q] = req[owner_q];
            end else if (grant_found) begin
                ack[grant_idx] = 1'b1;
            end
        end
        xfer     = |ack;
        xfer_dat = data[xfer_idx*W +: W];
        rr_ptr_d = (grant_idx == OW'(N-1)) ? '0 : grant_idx + OW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            burst_cnt_q <= '0;
            fifo_wr_q   <= 1'b0;
            fifo_din_q  <= '0;
        end else begin
            fifo_wr_q <= xfer;
            if (xfer) begin
                fifo_din_q <= xfer_dat;
            end
            case (state_q)
                IDLE: begin
                    if (xfer) begin
                        rr_ptr_q <= rr_ptr_d;
                        owner_q  <= grant_idx;
                        if (lock[grant_idx] && MAX_BURST > 1) begin
                            state_q     <= BURST;
                            burst_cnt_q <= 8'd1;
                        end
                    end
                end
                BURST: begin
                    // A full FIFO freezes the burst so ownership and count survive the stall.
                    if (!fifo_full) begin
                        if (!req[owner_q]) begin
                            state_q     <= IDLE;
                            burst_cnt_q <= '0;
                        end else if (!lock[owner_q] || (burst_cnt_q + 8'd1) == BURST_LAST) begin
                            state_q     <= IDLE;
                            burst_cnt_q <= '0;
                        end else begin
                            burst_cnt_q <= burst_cnt_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    burst_cnt_q <= '0;
                end
            endcase
        end
    end

    assign fifo_wr  = fifo_wr_q;
    assign fifo_din = fifo_din_q;
    assign busy     = (state_q == BURST);
    assign owner    = owner_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (W=8, N=4, MAX_BURST=4) with hand-computed expectations.
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [31:0] data;
    logic [3:0]  ack;
    logic        fifo_full;
    logic [7:0]  fifo_din;
    logic        fifo_wr;
    logic        busy;
    logic [1:0]  owner;

    int errors = 0;
    int checks = 0;

    fifo_wr_arbiter #(.W(8), .N(4), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .lock      (lock),
        .data      (data),
        .ack       (ack),
        .fifo_full (fifo_full),
        .fifo_din  (fifo_din),
        .fifo_wr   (fifo_wr),
        .busy      (busy),
        .owner     (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; req = 4'hF; lock = 4'h0; data = 32'h3322_1100; fifo_full = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL reset_ack got=%b exp=0000", ack); end
        checks++; if (fifo_wr !== 1'b0) begin errors++; $display("FAIL reset_wr got=%b exp=0", fifo_wr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (owner !== 2'd0) begin errors++; $display("FAIL reset_owner got=%0d exp=0", owner); end
        checks++; if (fifo_din !== 8'h00) begin errors++; $display("FAIL reset_din got=%h exp=00", fifo_din); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL reset_first_ack got=%b exp=0001", ack); end
        req = 4'h0;
        tick();
        checks++; if (fifo_wr !== 1'b0) begin errors++; $display("FAIL reset_no_xfer got=%b exp=0", fifo_wr); end
    endtask

    task automatic test_rotation();
        logic [3:0] exp_ack;
        logic [7:0] exp_din;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            req = 4'hF; lock = 4'h0;
            #1;
            exp_ack = 4'b0001 << i;
            exp_din = 8'(i * 8'h11);
            checks++; if (ack !== exp_ack) begin errors++; $display("FAIL rot_ack%0d got=%b exp=%b", i, ack, exp_ack); end
            tick();
            checks++; if (fifo_wr !== 1'b1 || fifo_din !== exp_din) begin
                errors++; $display("FAIL rot_wr%0d got wr=%b din=%h exp wr=1 din=%h", i, fifo_wr, fifo_din, exp_din);
            end
        end
        @(negedge clk);
        req = 4'h0;
        tick();
        checks++; if (fifo_wr !== 1'b0 || fifo_din !== 8'h33) begin
            errors++; $display("FAIL rot_idle got wr=%b din=%h exp wr=0 din=33", fifo_wr, fifo_din);
        end
    endtask

    task automatic test_locked_burst();
        // rr_ptr=0 here; requester 0 locks for the full MAX_BURST of 4.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            req = 4'b0011; lock = 4'b0001; data[7:0] = 8'hA0 + 8'(k);
            #1;
            checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL burst_ack%0d got=%b exp=0001", k, ack); end
            tick();
            checks++; if (fifo_wr !== 1'b1 || fifo_din !== 8'hA0 + 8'(k)) begin
                errors++; $display("FAIL burst_wr%0d got wr=%b din=%h exp wr=1 din=%h", k, fifo_wr, fifo_din, 8'hA0 + 8'(k));
            end
            checks++; if (busy !== (k < 3)) begin errors++; $display("FAIL burst_busy%0d got=%b exp=%b", k, busy, (k < 3)); end
        end
        @(negedge clk);
        #1;
        checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL burst_next_ack got=%b exp=0010", ack); end
        tick();
        checks++; if (fifo_din !== 8'h11 || owner !== 2'd1) begin
            errors++; $display("FAIL burst_next_wr got din=%h owner=%0d exp din=11 owner=1", fifo_din, owner);
        end
    endtask

    task automatic test_backpressure();
        // rr_ptr=2: requester 2 bursts, stalls for 3 cycles, then finishes.
        data[23:16] = 8'hB0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            req = 4'b0100; lock = 4'b0100; data[23:16] = 8'hB0 + 8'(k);
            #1;
            checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL bp_ack%0d got=%b exp=0100", k, ack); end
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            fifo_full = 1'b1; data[23:16] = 8'hB2;
            #1;
            checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL bp_stall_ack%0d got=%b exp=0000", k, ack); end
            tick();
            checks++; if (fifo_wr !== 1'b0 || busy !== 1'b1 || fifo_din !== 8'hB1) begin
                errors++; $display("FAIL bp_stall%0d got wr=%b busy=%b din=%h exp wr=0 busy=1 din=b1", k, fifo_wr, busy, fifo_din);
            end
        end
        for (int k = 2; k < 4; k++) begin
            @(negedge clk);
            fifo_full = 1'b0; data[23:16] = 8'hB0 + 8'(k);
            #1;
            checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL bp_resume_ack%0d got=%b exp=0100", k, ack); end
            tick();
            checks++; if (fifo_wr !== 1'b1 || fifo_din !== 8'hB0 + 8'(k)) begin
                errors++; $display("FAIL bp_resume_wr%0d got wr=%b din=%h exp=%h", k, fifo_wr, fifo_din, 8'hB0 + 8'(k));
            end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_end_busy got=%b exp=0", busy); end
        @(negedge clk);
        req = 4'h0; lock = 4'h0;
        tick();
        checks++; if (fifo_wr !== 1'b0) begin errors++; $display("FAIL bp_end_wr got=%b exp=0", fifo_wr); end
    endtask

    task automatic test_wraparound();
        // rr_ptr=3 here.
        @(negedge clk);
        req = 4'b1000; lock = 4'h0;
        #1;
        checks++; if (ack !== 4'b1000) begin errors++; $display("FAIL wrap_r3 got=%b exp=1000", ack); end
        tick();
        checks++; if (owner !== 2'd3) begin errors++; $display("FAIL wrap_owner3 got=%0d exp=3", owner); end
        @(negedge clk);
        req = 4'b1001;
        #1;
        checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL wrap_r0 got=%b exp=0001", ack); end
        tick();
        @(negedge clk);
        #1;
        checks++; if (ack !== 4'b1000) begin errors++; $display("FAIL wrap_r3b got=%b exp=1000", ack); end
        tick();
        checks++; if (owner !== 2'd3 || fifo_din !== 8'h33) begin
            errors++; $display("FAIL wrap_final got owner=%0d din=%h exp owner=3 din=33", owner, fifo_din);
        end
        @(negedge clk);
        req = 4'h0;
    endtask

    task automatic test_reset_mid_burst();
        // rr_ptr=0 here.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            req = 4'b0001; lock = 4'b0001; data[7:0] = 8'hC0 + 8'(k);
            #1;
            checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL rmb_ack%0d got=%b exp=0001", k, ack); end
            tick();
        end
        checks++; if (fifo_wr !== 1'b1 || fifo_din !== 8'hC2) begin
            errors++; $display("FAIL rmb_third got wr=%b din=%h exp wr=1 din=c2", fifo_wr, fifo_din);
        end
        #1;
        rst = 1'b0;
        #1;
        checks++; if (fifo_wr !== 1'b0 || busy !== 1'b0 || ack !== 4'b0000 || owner !== 2'd0) begin
            errors++; $display("FAIL rmb_async got wr=%b busy=%b ack=%b owner=%0d exp 0/0/0000/0", fifo_wr, busy, ack, owner);
        end
        @(negedge clk);
        rst = 1'b1; req = 4'b0110; lock = 4'h0;
        #1;
        checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL rmb_after_ack got=%b exp=0010", ack); end
        tick();
        checks++; if (fifo_wr !== 1'b1 || fifo_din !== 8'h11 || owner !== 2'd1) begin
            errors++; $display("FAIL rmb_after_wr got wr=%b din=%h owner=%0d exp wr=1 din=11 owner=1", fifo_wr, fifo_din, owner);
        end
        @(negedge clk);
        req = 4'h0;
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_locked_burst();
        test_backpressure();
        test_wraparound();
        test_reset_mid_burst();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
